mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width of all address ports.
REQ-002 Parameter WAIT_CYCLES, default 1, extra memory wait states per access (0..15).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 c_req / c_we  input  1 / 1  core access request (level) and write select.
REQ-006 c_addr / c_wdata  input  AW / 32  core byte address and write data.
REQ-007 c_store  input  2  core store size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-008 c_rdata / c_ready  output  32 / 1  core read word and one-cycle completion pulse.
REQ-009 d_req / d_we  input  1 / 1  DMA/loader request (level) and write select; word accesses only.
REQ-010 d_addr / d_wdata  input  AW / 32  DMA word address and write data.
REQ-011 d_rdata / d_ready  output  32 / 1  DMA read word and one-cycle completion pulse.
REQ-012 m_en / m_we  output  1 / 1  memory enable and write enable.
REQ-013 m_be  output  4  byte-lane write enables.
REQ-014 m_addr / m_wdata  output  AW / 32  memory address and lane-replicated write data.
REQ-015 m_rdata  input  32  memory read data, valid on final access cycle.

Function
REQ-016 FSM states IDLE, ACC, RESP; sole owner of the single memory port.
REQ-017 IDLE: no request -> stay; any request -> latch winner's address/data/we/size, go ACC.
REQ-018 Arbitration round-robin via 1-bit last_grant; both requesting -> grant the one not last granted; last_grant=DMA after reset so core wins first tie.
REQ-019 ACC: m_en=1, m_addr/m_we/m_be/m_wdata from latched request, held stable for WAIT_CYCLES+1 cycles via wait counter; counter expiry -> capture m_rdata, go RESP.
REQ-020 RESP: pulse granted side's ready for exactly one cycle, update last_grant, go IDLE; requests ignored in RESP.
REQ-021 Latency: request sampled at edge N -> ready high in cycle N+WAIT_CYCLES+2; next access starts no earlier than the IDLE cycle after RESP.
REQ-022 Requester holds req and fields stable until its ready; requester changes after latching have no effect.
REQ-023 m_be on write: word 1111; half 0011 or 1100 by addr[1]; byte 0001<<addr[1:0]; on read m_be=0000.
REQ-024 m_wdata: half replicated to both halves, byte replicated to all four lanes, word unchanged.
REQ-025 Misaligned write (half with addr[0]=1, word with addr[1:0]!=0): m_be=0000, m_we=0, access still runs and ready still pulses.
REQ-026 DMA accesses use m_be=1111 on writes, ignore d_addr[1:0].
REQ-027 c_rdata/d_rdata hold the last captured word of that side until its next completion; raw word, no load extraction.
REQ-028 Outputs m_en, m_we, m_be, ready pulses are zero whenever state is not ACC/RESP respectively.

Reset
REQ-029 rstn low: state IDLE, counter 0, last_grant DMA, all outputs and rdata registers 0, immediately (asynchronously).
REQ-030 Reset mid-ACC aborts the access with no ready pulse; no memory write after rstn asserts.

Structure
REQ-031 Package mem_arb_pkg holds state encoding, store-size codes (SW 00, SH 01, SB 10), and WAIT_CYCLES width constant.
REQ-032 One sub-module be_gen: combinational size/address -> m_be and replicated m_wdata, plus misalign flag.

Verification
REQ-033 WAIT_CYCLES=1, core read addr 0x40, m_rdata=0xDEADBEEF -> m_en high 2 cycles, c_ready in cycle N+3, c_rdata=0xDEADBEEF.
REQ-034 Core SB addr 0x103, wdata 0x000000A5 -> m_be=1000, m_wdata=0xA5A5A5A5, m_we=1.
REQ-035 Both requesters held continuously after reset -> grants alternate core, DMA, core, DMA; no side served twice in a row.
REQ-036 Core SH addr 0x101 -> m_be=0000, m_we=0, c_ready still pulses once.
REQ-037 rstn pulsed low during second ACC cycle of DMA write -> m_en/m_we drop immediately, no d_ready, next access after reset starts from IDLE.
REQ-038 WAIT_CYCLES=0, DMA write 0x200 data 0x12345678 -> m_be=1111, d_ready in cycle N+2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the memory arbiter   rev 1.0 |
// +--------------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SW = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SB = 2'b10;

  localparam int WAIT_W = 4;

  localparam logic GRANT_CORE = 1'b0;
  localparam logic GRANT_DMA  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_be_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | be_gen : store size/address -> byte enables, lane data, misalign  rev 1.0 |
// +--------------------------------------------------------------------------+
module be_gen
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign
);

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (size)
      SH: begin
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SB: begin
        wdata_rep = {4{wdata[7:0]}};
        be        = 4'b0001 << addr_lo;
      end
      default: begin
        misalign = (addr_lo != 2'b00);
        be       = 4'b1111;
      end
    endcase
    // Reads and misaligned writes must not touch any lane.
    if (!we || misalign) be = 4'b0000;
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter : round-robin core/DMA owner of a single memory port   rev 1.0 |
// +--------------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  input  logic [1:0]    c_store,
  output logic [31:0]   c_rdata,
  output logic          c_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic          m_en,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);
  localparam logic [AW-1:0]     WORD_MASK = ~(AW'(3));

  state_t            state, state_nx;
  logic              last_grant, owner, grant_sel, take, acc_done;
  logic [AW-1:0]     req_addr;
  logic [31:0]       req_wdata, wdata_rep;
  logic              req_we, misalign;
  logic [1:0]        req_size;
  logic [3:0]        be;
  logic [WAIT_W-1:0] wait_cnt;

  be_gen u_be_gen (
    .size      (req_size),
    .addr_lo   (req_addr[1:0]),
    .we        (req_we),
    .wdata     (req_wdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .misalign  (misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    acc_done = 1'b0;
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_be     = 4'b0000;
    m_addr   = '0;
    m_wdata  = '0;
    c_ready  = 1'b0;
    d_ready  = 1'b0;
    // On a tie the side that was not served last wins.
    grant_sel = (c_req && d_req) ? ~last_grant : d_req;
    case (state)
      ST_IDLE: begin
        if (c_req || d_req) begin
          take     = 1'b1;
          state_nx = ST_ACC;
        end
      end
      ST_ACC: begin
        m_en    = 1'b1;
        m_we    = req_we & ~misalign;
        m_be    = be;
        m_addr  = req_addr;
        m_wdata = wdata_rep;
        if (wait_cnt == WAIT_LAST) begin
          acc_done = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        c_ready  = (owner == GRANT_CORE);
        d_ready  = (owner == GRANT_DMA);
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= GRANT_DMA;
      owner      <= GRANT_CORE;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_we     <= 1'b0;
      req_size   <= SW;
      wait_cnt   <= '0;
      c_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      if (take) begin
        owner    <= grant_sel;
        wait_cnt <= '0;
        if (grant_sel == GRANT_CORE) begin
          req_addr  <= c_addr;
          req_wdata <= c_wdata;
          req_we    <= c_we;
          req_size  <= c_store;
        end else begin
          req_addr  <= d_addr & WORD_MASK;
          req_wdata <= d_wdata;
          req_we    <= d_we;
          req_size  <= SW;
        end
      end else if (state == ST_ACC && !acc_done) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (acc_done) begin
        if (owner == GRANT_CORE) c_rdata <= m_rdata;
        else                     d_rdata <= m_rdata;
      end
      if (state == ST_RESP) last_grant <= owner;
    end
  end

endmodule
`default_nettype wire
